// File: rtl/dsp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dsp_pkg
// Description : Shared mode encodings, accumulation FSM state type and signed
//               saturation helpers for the multi-lane DSP slice.
// Revision    : 1.0 - initial release
// ============================================================================
package dsp_pkg;

   localparam logic [1:0] MODE_ADD = 2'b00;
   localparam logic [1:0] MODE_MUL = 2'b01;
   localparam logic [1:0] MODE_MAC = 2'b10;
   localparam logic [1:0] MODE_DOT = 2'b11;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_ACCUM = 1'b1
   } acc_state_t;

   // Clamp a wide signed value into the signed range of a w-bit number.
   // Callers keep the low w bits of the result.
   function automatic logic signed [63:0] sat_val(input logic signed [63:0] v,
                                                  input int unsigned w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (v > hi)
         return hi;
      else if (v < lo)
         return lo;
      else
         return v;
   endfunction

   // True when sat_val would have clamped the value.
   function automatic logic sat_hit(input logic signed [63:0] v,
                                    input int unsigned w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      return (v > hi) || (v < lo);
   endfunction

endpackage
`default_nettype wire

// File: rtl/dsp_slice_lanes_lane.sv
`default_nettype none
// ============================================================================
// Module      : dsp_lane
// Description : One DSP lane: operand registers, registered product and sum,
//               and a saturating per-lane accumulator driven by the top FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module dsp_lane
   import dsp_pkg::*;
#(
   parameter int DWIDTH = 8,
   parameter int ACCW   = 24
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DWIDTH-1:0]     a_in,
   input  logic [DWIDTH-1:0]     b_in,
   input  logic                  acc_load,
   input  logic                  acc_en,
   input  logic [ACCW-1:0]       acc_in,
   output logic [2*DWIDTH-1:0]   prod,
   output logic [DWIDTH:0]       sum,
   output logic [ACCW-1:0]       acc,
   output logic                  acc_sticky
);

   logic signed [DWIDTH-1:0]   a_q;
   logic signed [DWIDTH-1:0]   b_q;
   logic signed [2*DWIDTH-1:0] prod_q;
   logic signed [DWIDTH:0]     sum_q;
   logic signed [ACCW-1:0]     acc_q;
   logic                       sticky_q;

   logic signed [ACCW-1:0]     acc_in_s;
   logic signed [63:0]         acc_wide;
   logic signed [63:0]         acc_clamped;
   logic                       acc_clip;

   assign acc_in_s    = acc_in;
   assign acc_wide    = 64'(acc_q) + 64'(acc_in_s);
   assign acc_clamped = sat_val(acc_wide, ACCW);
   assign acc_clip    = sat_hit(acc_wide, ACCW);

   // S1: capture the lane operands.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_q <= '0;
         b_q <= '0;
      end else begin
         a_q <= a_in;
         b_q <= b_in;
      end
   end

   // S2: full-precision signed product and one-bit-wider signed sum.
   always_ff @(posedge clk) begin
      if (reset) begin
         prod_q <= '0;
         sum_q  <= '0;
      end else begin
         prod_q <= $signed({{DWIDTH{a_q[DWIDTH-1]}}, a_q}) *
                   $signed({{DWIDTH{b_q[DWIDTH-1]}}, b_q});
         sum_q  <= $signed({a_q[DWIDTH-1], a_q}) + $signed({b_q[DWIDTH-1], b_q});
      end
   end

   // Accumulator: a load starts a fresh run (clearing the sticky clamp flag),
   // an enable adds with saturation and remembers any clamp.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q    <= '0;
         sticky_q <= 1'b0;
      end else if (acc_load) begin
         acc_q    <= acc_in_s;
         sticky_q <= 1'b0;
      end else if (acc_en) begin
         acc_q    <= acc_clamped[ACCW-1:0];
         sticky_q <= sticky_q | acc_clip;
      end
   end

   assign prod       = prod_q;
   assign sum        = sum_q;
   assign acc        = acc_q;
   assign acc_sticky = sticky_q;

endmodule
`default_nettype wire

// File: rtl/dsp_slice_lanes.sv
`default_nettype none
// ============================================================================
// Module      : dsp_slice_lanes
// Description : Pipelined multi-lane signed DSP slice (add / mul / mac / dot)
//               with saturating results and a shared accumulation FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module dsp_slice_lanes
   import dsp_pkg::*;
#(
   parameter int DWIDTH = 8,
   parameter int LANES  = 4,
   parameter int ACCW   = 24,
   parameter int CNTW   = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   input  logic [1:0]                mode,
   input  logic [CNTW-1:0]           acc_len,
   input  logic [LANES*DWIDTH-1:0]   a_in,
   input  logic [LANES*DWIDTH-1:0]   b_in,
   output logic                      out_valid,
   output logic                      out_last,
   output logic [LANES*DWIDTH-1:0]   c_out,
   output logic [LANES-1:0]          sat_flag
);

   // Control pipeline alongside the lane data registers.
   logic            s1_valid, s2_valid;
   logic [1:0]      s1_mode, s2_mode;
   logic [CNTW-1:0] s1_len, s2_len;

   // Lane results.
   logic signed [2*DWIDTH-1:0] prod_w   [LANES];
   logic signed [DWIDTH:0]     sum_w    [LANES];
   logic signed [ACCW-1:0]     acc_w    [LANES];
   logic                       sticky_w [LANES];
   logic signed [ACCW-1:0]     acc_in_w [LANES];

   // FSM state and stage-3 pending result registers.
   acc_state_t              state;
   logic [1:0]              acc_mode;
   logic [CNTW-1:0]         len_q;
   logic [CNTW-1:0]         count;
   logic                    p_valid;
   logic                    p_last;
   logic                    p_dot;
   logic [LANES*DWIDTH-1:0] p_res;
   logic [LANES-1:0]        p_flag;

   // Decode of the beat currently in S2.
   logic            acc_load, acc_en, start, emit, addmul;
   logic [CNTW-1:0] len_eff, cnt_next;
   logic signed [ACCW-1:0]  tree_w;
   logic [LANES*DWIDTH-1:0] am_res;
   logic [LANES-1:0]        am_flag;
   logic signed [63:0]      am_wide [LANES];
   logic signed [63:0]      am_sat  [LANES];
   logic [LANES*DWIDTH-1:0] em_res;
   logic [LANES-1:0]        em_flag;
   logic signed [63:0]      em_wide [LANES];
   logic signed [63:0]      em_sat  [LANES];

   // S1/S2 registers for valid, mode and accumulation length.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         s1_mode  <= MODE_ADD;
         s2_mode  <= MODE_ADD;
         s1_len   <= '0;
         s2_len   <= '0;
      end else begin
         s1_valid <= in_valid;
         s2_valid <= s1_valid;
         s1_mode  <= mode;
         s2_mode  <= s1_mode;
         s1_len   <= acc_len;
         s2_len   <= s1_len;
      end
   end

   generate
      for (genvar i = 0; i < LANES; i++) begin : g_lane
         dsp_lane #(
            .DWIDTH (DWIDTH),
            .ACCW   (ACCW)
         ) u_lane (
            .clk        (clk),
            .reset      (reset),
            .a_in       (a_in[i*DWIDTH +: DWIDTH]),
            .b_in       (b_in[i*DWIDTH +: DWIDTH]),
            .acc_load   (acc_load),
            .acc_en     (acc_en),
            .acc_in     (acc_in_w[i]),
            .prod       (prod_w[i]),
            .sum        (sum_w[i]),
            .acc        (acc_w[i]),
            .acc_sticky (sticky_w[i])
         );
      end
   endgenerate

   // Dot-product tree: all lane products sign-extended to the accumulator width.
   always_comb begin
      tree_w = '0;
      for (int i = 0; i < LANES; i++)
         tree_w = tree_w + ACCW'(prod_w[i]);
   end

   // Accumulator operands: each lane takes its own product, except lane 0 in
   // dot mode, which takes the cross-lane tree sum.
   always_comb begin
      for (int i = 0; i < LANES; i++)
         acc_in_w[i] = ACCW'(prod_w[i]);
      if (s2_mode == MODE_DOT)
         acc_in_w[0] = tree_w;
   end

   // Saturated add/mul result for the beat in S2.
   always_comb begin
      am_res  = '0;
      am_flag = '0;
      for (int i = 0; i < LANES; i++) begin
         am_wide[i] = (s2_mode == MODE_MUL) ? 64'(prod_w[i]) : 64'(sum_w[i]);
         am_sat[i]  = sat_val(am_wide[i], DWIDTH);
         am_res[i*DWIDTH +: DWIDTH] = am_sat[i][DWIDTH-1:0];
         am_flag[i] = sat_hit(am_wide[i], DWIDTH);
      end
   end

   // Beat decode: start, continue or abandon an accumulation.
   always_comb begin
      acc_load = 1'b0;
      acc_en   = 1'b0;
      start    = 1'b0;
      emit     = 1'b0;
      addmul   = 1'b0;
      len_eff  = (s2_len == '0) ? CNTW'(1) : s2_len;
      cnt_next = count + CNTW'(1);
      if (s2_valid) begin
         if (!s2_mode[1]) begin
            addmul = 1'b1;
         end else if (state == ST_IDLE || s2_mode != acc_mode) begin
            acc_load = 1'b1;
            start    = 1'b1;
            emit     = (len_eff == CNTW'(1));
         end else begin
            acc_en = 1'b1;
            emit   = (cnt_next == len_q);
         end
      end
   end

   // Accumulation FSM and stage-3 pending result registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         acc_mode <= MODE_ADD;
         len_q    <= '0;
         count    <= '0;
         p_valid  <= 1'b0;
         p_last   <= 1'b0;
         p_dot    <= 1'b0;
         p_res    <= '0;
         p_flag   <= '0;
      end else begin
         p_valid <= addmul | emit;
         p_last  <= emit;
         if (emit)
            p_dot <= (s2_mode == MODE_DOT);
         if (addmul) begin
            state  <= ST_IDLE;
            count  <= '0;
            p_res  <= am_res;
            p_flag <= am_flag;
         end else if (start) begin
            len_q    <= len_eff;
            acc_mode <= s2_mode;
            count    <= CNTW'(1);
            state    <= emit ? ST_IDLE : ST_ACCUM;
         end else if (acc_en) begin
            count <= cnt_next;
            if (emit)
               state <= ST_IDLE;
         end
      end
   end

   // Saturated accumulator view used when an accumulation result is emitted.
   always_comb begin
      em_res  = '0;
      em_flag = '0;
      for (int i = 0; i < LANES; i++) begin
         em_wide[i] = 64'(acc_w[i]);
         em_sat[i]  = sat_val(em_wide[i], DWIDTH);
         if (!p_dot || i == 0) begin
            em_res[i*DWIDTH +: DWIDTH] = em_sat[i][DWIDTH-1:0];
            em_flag[i] = sticky_w[i] | sat_hit(em_wide[i], DWIDTH);
         end
      end
   end

   // Output registers; data and flags hold between result beats.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         c_out     <= '0;
         sat_flag  <= '0;
      end else if (p_valid) begin
         out_valid <= 1'b1;
         out_last  <= p_last;
         c_out     <= p_last ? em_res  : p_res;
         sat_flag  <= p_last ? em_flag : p_flag;
      end else begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dsp_slice_lanes.sv
`default_nettype none
// ============================================================================
// Module      : tb_dsp_slice_lanes
// Description : Directed self-checking bench for dsp_slice_lanes
//               (DWIDTH=8, LANES=4, ACCW=24).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dsp_slice_lanes;

   localparam logic [1:0] M_ADD = 2'b00;
   localparam logic [1:0] M_MUL = 2'b01;
   localparam logic [1:0] M_MAC = 2'b10;
   localparam logic [1:0] M_DOT = 2'b11;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [1:0]  mode;
   logic [15:0] acc_len;
   logic [31:0] a_in;
   logic [31:0] b_in;
   logic        out_valid;
   logic        out_last;
   logic [31:0] c_out;
   logic [3:0]  sat_flag;

   int n_cmp  = 0;
   int n_fail = 0;

   dsp_slice_lanes #(
      .DWIDTH (8),
      .LANES  (4),
      .ACCW   (24),
      .CNTW   (16)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .mode      (mode),
      .acc_len   (acc_len),
      .a_in      (a_in),
      .b_in      (b_in),
      .out_valid (out_valid),
      .out_last  (out_last),
      .c_out     (c_out),
      .sat_flag  (sat_flag)
   );

   always #5 clk = ~clk;

   // Advance past one rising edge and settle.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [1:0] m, input logic [15:0] len,
                       input logic [31:0] a, input logic [31:0] b);
      in_valid = 1'b1;
      mode     = m;
      acc_len  = len;
      a_in     = a;
      b_in     = b;
      step();
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      a_in     = '0;
      b_in     = '0;
      repeat (n) step();
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic v, input logic l,
                             input logic [31:0] c, input logic [3:0] f);
      check({tag, ".valid"}, 32'(out_valid), 32'(v));
      check({tag, ".last"},  32'(out_last),  32'(l));
      check({tag, ".c"},     c_out,          c);
      check({tag, ".flag"},  32'(sat_flag),  32'(f));
   endtask

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      mode     = M_ADD;
      acc_len  = '0;
      a_in     = '0;
      b_in     = '0;
      step();
      step();
      reset = 1'b0;
      expect_out("reset", 1'b0, 1'b0, 32'h0, 4'h0);

      // add: 100+50 clamps to 127, -3+-4 = -7
      beat(M_ADD, 16'd1, 32'h0000_FD64, 32'h0000_FC32);
      idle(3);
      expect_out("add", 1'b1, 1'b0, 32'h0000_F97F, 4'b0001);
      idle(1);
      check("add.drop", 32'(out_valid), 32'h0);

      // mul back-to-back on lane 2: -128*-128 clamps, then 5*-6 = -30
      beat(M_MUL, 16'd1, 32'h0080_0000, 32'h0080_0000);
      beat(M_MUL, 16'd1, 32'h0005_0000, 32'h00FA_0000);
      idle(2);
      expect_out("mul1", 1'b1, 1'b0, 32'h007F_0000, 4'b0100);
      idle(1);
      expect_out("mul2", 1'b1, 1'b0, 32'h00E2_0000, 4'b0000);

      // mac len 4 with a two-cycle gap: 4 * (3*4) = 48
      beat(M_MAC, 16'd4, 32'h0000_0003, 32'h0000_0004);
      beat(M_MAC, 16'd4, 32'h0000_0003, 32'h0000_0004);
      idle(2);
      beat(M_MAC, 16'd4, 32'h0000_0003, 32'h0000_0004);
      beat(M_MAC, 16'd4, 32'h0000_0003, 32'h0000_0004);
      idle(2);
      check("mac.early", 32'(out_valid), 32'h0);
      idle(1);
      expect_out("mac1", 1'b1, 1'b1, 32'h0000_0030, 4'b0000);
      // second run restarts from zero; acc_len changes mid-run are ignored
      beat(M_MAC, 16'd4, 32'h0000_0003, 32'h0000_0004);
      beat(M_MAC, 16'd9, 32'h0000_0003, 32'h0000_0004);
      beat(M_MAC, 16'd9, 32'h0000_0003, 32'h0000_0004);
      beat(M_MAC, 16'd9, 32'h0000_0003, 32'h0000_0004);
      idle(3);
      expect_out("mac2", 1'b1, 1'b1, 32'h0000_0030, 4'b0000);

      // dot len 2: (1+2+3+4) * 2 = 20 on lane 0
      beat(M_DOT, 16'd2, 32'h0403_0201, 32'h0101_0101);
      beat(M_DOT, 16'd2, 32'h0403_0201, 32'h0101_0101);
      idle(3);
      expect_out("dot", 1'b1, 1'b1, 32'h0000_0014, 4'b0000);

      // mac interrupted by add: only the add result (2) appears
      beat(M_MAC, 16'd3, 32'h0000_0002, 32'h0000_0003);
      beat(M_MAC, 16'd3, 32'h0000_0002, 32'h0000_0003);
      beat(M_ADD, 16'd3, 32'h0000_0001, 32'h0000_0001);
      idle(3);
      expect_out("intr.add", 1'b1, 1'b0, 32'h0000_0002, 4'b0000);
      beat(M_MAC, 16'd3, 32'h0000_0001, 32'h0000_0001);
      beat(M_MAC, 16'd3, 32'h0000_0001, 32'h0000_0001);
      beat(M_MAC, 16'd3, 32'h0000_0001, 32'h0000_0001);
      idle(3);
      expect_out("intr.mac", 1'b1, 1'b1, 32'h0000_0003, 4'b0000);

      // reset mid-accumulation clears outputs and drops the partial sum
      beat(M_MAC, 16'd4, 32'h0000_0005, 32'h0000_0005);
      beat(M_MAC, 16'd4, 32'h0000_0005, 32'h0000_0005);
      reset    = 1'b1;
      in_valid = 1'b0;
      step();
      reset = 1'b0;
      expect_out("rst.mid", 1'b0, 1'b0, 32'h0, 4'h0);
      beat(M_MAC, 16'd2, 32'h0000_0002, 32'h0000_0002);
      beat(M_MAC, 16'd2, 32'h0000_0002, 32'h0000_0002);
      idle(3);
      expect_out("rst.mac", 1'b1, 1'b1, 32'h0000_0008, 4'b0000);

      // acc_len = 0 behaves as a single-beat accumulation: 7*7 = 49
      beat(M_MAC, 16'd0, 32'h0000_0007, 32'h0000_0007);
      idle(3);
      expect_out("len0", 1'b1, 1'b1, 32'h0000_0031, 4'b0000);

      // single-beat mac 127*127 clamps at the output
      beat(M_MAC, 16'd1, 32'h0000_007F, 32'h0000_007F);
      idle(3);
      expect_out("mac.sat", 1'b1, 1'b1, 32'h0000_007F, 4'b0001);

      // single-beat dot of -128*127 per lane = -65024, clamps to -128 on lane 0
      beat(M_DOT, 16'd1, 32'h8080_8080, 32'h7F7F_7F7F);
      idle(3);
      expect_out("dot.sat", 1'b1, 1'b1, 32'h0000_0080, 4'b0001);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dsp_slice_lanes.md
# dsp_slice_lanes

Parametrised, pipelined multi-lane integer DSP slice. It performs per-lane signed add, multiply, multiply-accumulate, or cross-lane dot-product over a programmable number of input beats. Results saturate to the lane width. It sits between the operand-fetch logic and the result writeback path, wherever several narrow MAC units are packed into one hard block.

## Interface
- `DWIDTH`, 8: lane operand/result width, signed two's complement.
- `LANES`, 4: number of lanes; ≥1.
- `ACCW`, 24: accumulator width; ≥ 2*`DWIDTH` + clog2(`LANES`).
- `CNTW`, 16: width of `acc_len`.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  input beat valid; no backpressure.
- `mode`  in  2  00 add, 01 mul, 10 mac, 11 dot; sampled per beat.
- `acc_len`  in  `CNTW`  beats per accumulation (mac/dot); 0 treated as 1.
- `a_in`  in  `LANES`*`DWIDTH`  lane i at bits [i*DWIDTH +: DWIDTH].
- `b_in`  in  `LANES`*`DWIDTH`  same packing.
- `out_valid`  out  1  result beat valid.
- `out_last`  out  1  high with `out_valid` on an accumulation result (mac/dot).
- `c_out`  out  `LANES`*`DWIDTH`  results; held when `out_valid`=0.
- `sat_flag`  out  `LANES`  per-lane clamp occurred in this result beat.

## Operation
- **S1:** register `a_in`, `b_in`, `mode`, `in_valid`.
- **S2:** per lane, register the signed product (2*`DWIDTH`) and the signed sum (`DWIDTH`+1).
- **S3:** mode-dependent result, then output registers.
  - **add:** `c_out`[i] = sat(a+b).
  - **mul:** `c_out`[i] = sat(a*b). Integer result; no shift.
  - **mac:** per-lane `acc`[i] += product, saturating at `ACCW`.
  - **dot:** `acc`[0] += sum of all lane products, via an adder tree sign-extended to `ACCW`, saturating at `ACCW`.
- **Accumulation FSM**, one per block, states IDLE and ACCUM:
  - **IDLE:** a valid mac/dot beat loads acc = product. It latches `acc_len` (`len_q`) and the mode, and sets count=1. If `len_q` ≤ 1, it emits immediately and stays in IDLE; otherwise it goes to ACCUM.
  - **ACCUM:** each valid beat of the same mode accumulates and increments count. When count reaches `len_q` it emits and returns to IDLE, with the accumulator logically cleared.
- **Emit** means: `out_valid`=1, `out_last`=1, `c_out`[i] = sat(`acc`[i]). In dot mode, lane 0 carries the result and the other lanes are 0.
- **Mode change** (add/mul, or the other accumulate mode) while in ACCUM: the partial accumulation is discarded without output and count is reset. A new-mode mac/dot beat starts a fresh accumulation; an add/mul beat is processed normally.
- Beats with `in_valid`=0 leave all state unchanged.
- `sat()` clamps to [-2^(`DWIDTH`-1), 2^(`DWIDTH`-1)-1]. `sat_flag`[i] is set if the output clamp or any `ACCW` clamp fired for that lane during the emitted result. The `ACCW`-clamp indication is sticky across the accumulation.
- **Reset:** all pipeline valids and the FSM go to IDLE. Count, accumulators, `c_out`, `sat_flag`, `out_valid` and `out_last` all go to 0. Reset mid-accumulation drops the partial result.

## Timing
- Fixed latency of 3 for every mode. A beat sampled at edge t produces, if it emits, `out_valid` visible after edge t+3.
- Throughput is 1 beat/cycle in all modes. Non-final mac/dot beats produce `out_valid`=0.
- Back-to-back accumulations need no idle cycle: the last beat of one and the first beat of the next may be consecutive.
- `acc_len` is only sampled on the first beat of an accumulation. Changes during ACCUM are ignored.

## Structure
- **Package `dsp_pkg`:** mode encoding constants (`MODE_ADD`, `MODE_MUL`, `MODE_MAC`, `MODE_DOT`), the FSM state type, and a parametrised signed saturate function.
- **Sub-module `dsp_lane`:** S1/S2 registers, product, sum and per-lane accumulator for one lane; instantiated `LANES` times.
- **Top level:** the FSM, the dot-product adder tree, and the output mux/registers.

## Test plan
All scenarios use `DWIDTH`=8, `LANES`=4, `ACCW`=24.
1. **add, one beat:** lane0 100+50, lane1 -3+-4 → after 3 cycles lane0=127 with `sat_flag`[0]=1, lane1=-7, `out_last`=0.
2. **mul, back-to-back beats:** -128*-128 then 5*-6 on lane2 → consecutive `out_valid`; lane2 = 127 (sat), then -30.
3. **mac, `acc_len`=4, with a 2-cycle `in_valid` gap:** lane0 3*4 each beat → a single output of 48 with `out_last`=1. A following 4-beat run also yields 48, not 96.
4. **dot, `acc_len`=2:** a={1,2,3,4}, b={1,1,1,1} twice → lane0=20, lanes1-3=0, `out_last`=1.
5. **mac interrupted:** mac `acc_len`=3 for two beats, then add 1+1 → only the add result (2) is output. A following 3-beat mac of 1*1 gives 3.
6. **reset mid-accumulation:** reset during a mac → all outputs 0 next cycle. A post-reset mac `acc_len`=2 of 2*2 gives 8.
